score_leaderboard: RTL and testbench
====================================

Name: score_leaderboard

Overview:
- Parametrised successor to the single best-score tracker. Keeps a sorted table of the DEPTH best (lowest) reaction times since the last reset or clear.
- Each new result is ranked on insertion. Outputs: the new result's rank, a high-score flag, and the current best time.
- Sits between the reaction-time counter/FSM and the display mux. The display can scan any table entry through a read port.

Parameters:
- SCORE_WIDTH, 14, width of a reaction time in ms.
- DEPTH, 4, number of table entries (≥1).
- RANK_WIDTH, $clog2(DEPTH+1), width of rank outputs. Derived; do not override.
- IDX_WIDTH, ($clog2(DEPTH) ≥ 1 ? $clog2(DEPTH) : 1), width of read index. Derived.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; empties table.
- clear_scores  in  1  synchronous clear of table; same effect as reset on table state.
- score_valid  in  1  one-cycle pulse: score_in is a completed, valid result.
- score_in  in  SCORE_WIDTH  reaction time to rank.
- rd_index  in  IDX_WIDTH  table read address, 0 = best.
- rd_score  out  SCORE_WIDTH  table[rd_index]. Combinational from registers. All-ones if slot empty or index ≥ DEPTH.
- rd_used  out  1  slot rd_index holds a score.
- best_score  out  SCORE_WIDTH  table[0]. All-ones when empty.
- entry_count  out  RANK_WIDTH  number of occupied slots, 0..DEPTH.
- rank_valid  out  1  one-cycle pulse, one cycle after an accepted or rejected score_valid.
- rank  out  RANK_WIDTH  1-based rank of last score. 0 = did not make the table or was rejected. Held until next rank_valid.
- is_high_score  out  1  high while the last ranked score is rank 1. Held with rank.

Behaviour:
- **Storage:** DEPTH registers of SCORE_WIDTH plus DEPTH used bits. The table is always sorted ascending over used slots, and used slots are contiguous from index 0.
- **Reset/clear:**
  - All slots become all-ones and unused; entry_count=0.
  - rank=0, is_high_score=0, rank_valid=0.
  - reset and clear_scores are equivalent and take priority over score_valid in the same cycle; that score is dropped and no rank_valid is produced.
- **Rejection:** score_in == all-ones (timeout/sentinel) is rejected. rank_valid still pulses next cycle with rank=0, is_high_score=0, and the table is unchanged.
- **Insertion, single cycle on score_valid:**
  - Position p = number of used slots with value ≤ score_in.
  - Ties: the new score goes after existing equal scores, so the earlier equal score keeps the better rank.
  - If p < DEPTH: slots p..DEPTH-2 shift down one, slot p ← score_in, and entry_count increments, saturating at DEPTH. When full, the worst entry is discarded.
  - If p == DEPTH (table full, score not better than the worst): table unchanged, rank=0.
- **Outputs:**
  - Cycle after an accepted insertion: rank_valid=1, rank=p+1, is_high_score=(p==0). The table, best_score and entry_count are already updated that cycle.
  - The first score after reset always gets rank 1.
- **Back-to-back:** score_valid on consecutive cycles is legal. Each is ranked against the table as updated by the previous one. The rank_valid pulses appear on consecutive cycles.
- **Timing:** no combinational path from score_valid/score_in to rank or is_high_score. The comparator bank is DEPTH parallel ≤ compares on score_in.
- **Read port:** purely combinational and independent of insertion. It reflects the registered table.

Test Plan:
- Reset, then score 500 → next cycle rank_valid=1, rank=1, is_high_score=1, best_score=500, entry_count=1.
- DEPTH=4: scores 400, 300, 350, 200 → ranks 1, 1, 2, 1; final table 200, 300, 350, 400; entry_count=4.
- Full table 200/300/350/400, score 400 → rank=0, table unchanged. Score 250 → rank=2, table 200/250/300/350 (400 dropped).
- Tie: table 200/300, score 300 → rank=3; rd_index=2 reads 300. Score all-ones (16383) → rank=0, count unchanged.
- clear_scores and score_valid same cycle → no rank_valid, entry_count=0, best_score=16383. Reset asserted mid-sequence behaves identically.
- Back-to-back pulses 600, 100 on consecutive cycles → rank_valid on two consecutive cycles with ranks 1, 1; best_score=100.

Source files
------------

// File: rtl/score_leaderboard.sv
// score_leaderboard: sorted table of the DEPTH best (lowest) reaction times.
// Each valid score is ranked and inserted in one cycle. The rank and the
// high-score flag are registered and appear one cycle later. A combinational
// read port lets the display scan the table.
module score_leaderboard #(
  parameter int SCORE_WIDTH = 14,
  parameter int DEPTH       = 4,
  parameter int RANK_WIDTH  = $clog2(DEPTH + 1),
  parameter int IDX_WIDTH   = ($clog2(DEPTH) >= 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear_scores,
  input  logic                   score_valid,
  input  logic [SCORE_WIDTH-1:0] score_in,
  input  logic [IDX_WIDTH-1:0]   rd_index,
  output logic [SCORE_WIDTH-1:0] rd_score,
  output logic                   rd_used,
  output logic [SCORE_WIDTH-1:0] best_score,
  output logic [RANK_WIDTH-1:0]  entry_count,
  output logic                   rank_valid,
  output logic [RANK_WIDTH-1:0]  rank,
  output logic                   is_high_score
);

  localparam logic [SCORE_WIDTH-1:0] EMPTY = '1;

  logic [SCORE_WIDTH-1:0] slot_reg  [DEPTH];
  logic [SCORE_WIDTH-1:0] slot_next [DEPTH];
  logic                   used_reg  [DEPTH];
  logic                   used_next [DEPTH];
  logic                   le        [DEPTH];
  logic [RANK_WIDTH-1:0]  count_reg;
  logic [RANK_WIDTH-1:0]  rank_reg;
  logic                   high_reg;
  logic                   rank_valid_reg;
  logic [RANK_WIDTH-1:0]  pos;
  logic                   room;
  logic                   accept;

  genvar gi;

  // Comparator bank: occupied slots whose value is <= the incoming score.
  // Using <= places a new score after any equal scores already stored.
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign le[gi] = used_reg[gi] && (slot_reg[gi] <= score_in);
    end
  endgenerate

  // Insertion position = number of slots that stay ahead of the new score.
  always_comb begin
    pos = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pos = pos + RANK_WIDTH'(le[i]);
    end
  end

  assign room   = (pos < RANK_WIDTH'(DEPTH));
  assign accept = score_valid && (score_in != EMPTY) && room;

  // Shifted table: slots before pos keep their value, slot pos takes the new
  // score, and later slots take their predecessor (the last one falls off).
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_shift
      if (gi == 0) begin : g_first
        assign slot_next[gi] = (pos == '0) ? score_in : slot_reg[gi];
        assign used_next[gi] = (pos == '0) ? 1'b1     : used_reg[gi];
      end else begin : g_rest
        assign slot_next[gi] = (pos == RANK_WIDTH'(gi)) ? score_in :
                               (pos <  RANK_WIDTH'(gi)) ? slot_reg[gi-1] : slot_reg[gi];
        assign used_next[gi] = (pos == RANK_WIDTH'(gi)) ? 1'b1 :
                               (pos <  RANK_WIDTH'(gi)) ? used_reg[gi-1] : used_reg[gi];
      end
    end
  endgenerate

  // Table, occupancy count and rank result registers.
  always_ff @(posedge clock) begin
    if (reset || clear_scores) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_reg[i] <= EMPTY;
        used_reg[i] <= 1'b0;
      end
      count_reg      <= '0;
      rank_reg       <= '0;
      high_reg       <= 1'b0;
      rank_valid_reg <= 1'b0;
    end else begin
      rank_valid_reg <= score_valid;
      if (accept) begin
        for (int i = 0; i < DEPTH; i++) begin
          slot_reg[i] <= slot_next[i];
          used_reg[i] <= used_next[i];
        end
        if (count_reg != RANK_WIDTH'(DEPTH)) begin
          count_reg <= count_reg + 1'b1;
        end
        rank_reg <= pos + 1'b1;
        high_reg <= (pos == '0);
      end else if (score_valid) begin
        rank_reg <= '0;
        high_reg <= 1'b0;
      end
    end
  end

  // Read port: selected slot, or all-ones for an empty slot or out-of-range index.
  always_comb begin
    rd_score = EMPTY;
    rd_used  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_index == IDX_WIDTH'(i)) begin
        rd_used  = used_reg[i];
        rd_score = used_reg[i] ? slot_reg[i] : EMPTY;
      end
    end
  end

  assign best_score    = used_reg[0] ? slot_reg[0] : EMPTY;
  assign entry_count   = count_reg;
  assign rank_valid    = rank_valid_reg;
  assign rank          = rank_reg;
  assign is_high_score = high_reg;

endmodule

// File: tb/tb_score_leaderboard.sv
// Testbench for score_leaderboard: directed steps from the test plan followed
// by random scores, all checked against a queue-based leaderboard model.
module tb_score_leaderboard;

  localparam int SW    = 14;
  localparam int DEPTH = 4;
  localparam int RW    = $clog2(DEPTH + 1);
  localparam int IW    = 2;
  localparam int ALL1  = 16383;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          clear_scores = 1'b0;
  logic          score_valid = 1'b0;
  logic [SW-1:0] score_in = '0;
  logic [IW-1:0] rd_index = '0;
  logic [SW-1:0] rd_score;
  logic          rd_used;
  logic [SW-1:0] best_score;
  logic [RW-1:0] entry_count;
  logic          rank_valid;
  logic [RW-1:0] rank;
  logic          is_high_score;

  int errors = 0;
  int checks = 0;
  int q[$];

  score_leaderboard #(.SCORE_WIDTH(SW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .clear_scores(clear_scores),
    .score_valid(score_valid), .score_in(score_in), .rd_index(rd_index),
    .rd_score(rd_score), .rd_used(rd_used), .best_score(best_score),
    .entry_count(entry_count), .rank_valid(rank_valid), .rank(rank),
    .is_high_score(is_high_score)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Leaderboard model: sorted list of best times; returns the 1-based rank or 0.
  function automatic int model_insert(input int s);
    int p;
    if (s == ALL1) return 0;
    p = 0;
    foreach (q[i]) if (q[i] <= s) p++;
    if (p >= DEPTH) return 0;
    q.insert(p, s);
    if (q.size() > DEPTH) void'(q.pop_back());
    return p + 1;
  endfunction

  function automatic int model_best();
    return (q.size() > 0) ? q[0] : ALL1;
  endfunction

  task automatic check_status(input string tag, input int exp_rank);
    check({tag, ".rank_valid"}, int'(rank_valid), 1);
    check({tag, ".rank"}, int'(rank), exp_rank);
    check({tag, ".high"}, int'(is_high_score), (exp_rank == 1) ? 1 : 0);
    check({tag, ".count"}, int'(entry_count), q.size());
    check({tag, ".best"}, int'(best_score), model_best());
  endtask

  // Single score pulse; outputs are checked on the following falling edge.
  task automatic send(input string tag, input int s);
    int r;
    @(negedge clock);
    score_valid = 1'b1;
    score_in    = SW'(s);
    @(negedge clock);
    score_valid = 1'b0;
    r = model_insert(s);
    check_status(tag, r);
    $display("score=%0d rank=%0d high=%0d count=%0d best=%0d", s, rank, is_high_score, entry_count, best_score);
  endtask

  task automatic check_table(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      rd_index = IW'(i);
      #1;
      check($sformatf("%s.rd_score[%0d]", tag, i), int'(rd_score), (i < q.size()) ? q[i] : ALL1);
      check($sformatf("%s.rd_used[%0d]", tag, i), int'(rd_used), (i < q.size()) ? 1 : 0);
    end
  endtask

  // Reset or clear asserted together with a score: the score must be dropped.
  task automatic wipe_with_score(input string tag, input bit use_reset, input int s);
    @(negedge clock);
    if (use_reset) reset = 1'b1; else clear_scores = 1'b1;
    score_valid = 1'b1;
    score_in    = SW'(s);
    @(negedge clock);
    reset = 1'b0; clear_scores = 1'b0; score_valid = 1'b0;
    q.delete();
    check({tag, ".rank_valid"}, int'(rank_valid), 0);
    check({tag, ".rank"}, int'(rank), 0);
    check({tag, ".high"}, int'(is_high_score), 0);
    check({tag, ".count"}, int'(entry_count), 0);
    check({tag, ".best"}, int'(best_score), ALL1);
    $display("wipe reset=%0d score=%0d count=%0d best=%0d", use_reset, s, entry_count, best_score);
  endtask

  initial begin
    int s;
    repeat (3) @(negedge clock);
    check("reset.rank_valid", int'(rank_valid), 0);
    check("reset.count", int'(entry_count), 0);
    check("reset.best", int'(best_score), ALL1);
    check("reset.rank", int'(rank), 0);
    reset = 1'b0;
    check_table("reset");

    // First score after reset is rank 1.
    send("first", 500);
    @(negedge clock);
    check("first.pulse_end", int'(rank_valid), 0);
    check("first.rank_held", int'(rank), 1);

    // Ordered fill.
    wipe_with_score("clr0", 1'b0, 0);
    send("fill400", 400);
    send("fill300", 300);
    send("fill350", 350);
    send("fill200", 200);
    check_table("fill");

    // Full table: not better than the worst, then a mid insertion.
    send("full400", 400);
    check_table("full400");
    send("full250", 250);
    check_table("full250");

    // Ties and the sentinel.
    wipe_with_score("clr1", 1'b0, 123);
    send("tie200", 200);
    send("tie300a", 300);
    send("tie300b", 300);
    rd_index = 2'd2;
    #1;
    check("tie.rd2", int'(rd_score), 300);
    send("sentinel", ALL1);
    check_table("sentinel");

    // Reset mid-sequence with a score in the same cycle.
    wipe_with_score("rst_mid", 1'b1, 50);
    check_table("rst_mid");

    // Back-to-back pulses.
    @(negedge clock);
    score_valid = 1'b1;
    score_in    = SW'(600);
    @(negedge clock);
    score_in    = SW'(100);
    check_status("b2b600", model_insert(600));
    $display("score=600 rank=%0d high=%0d", rank, is_high_score);
    @(negedge clock);
    score_valid = 1'b0;
    check_status("b2b100", model_insert(100));
    $display("score=100 rank=%0d high=%0d", rank, is_high_score);
    @(negedge clock);
    check("b2b.pulse_end", int'(rank_valid), 0);

    // Random scores over a small range so ties and a full table are common.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        wipe_with_score("rnd_clr", 1'b0, int'($urandom_range(0, 999)));
      end else begin
        s = ($urandom_range(0, 9) == 0) ? ALL1 : int'($urandom_range(0, 40));
        send("rnd", s);
        if (n % 8 == 0) check_table("rnd");
      end
    end
    check_table("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
